test_ctrl_mmio: RTL and testbench
=================================

# test_ctrl_mmio

Memory-mapped test-control responder for the SOPC: it sits on the data-bus side and receives results from the CPU core, while the bench only drives clock and reset. It captures the pass/fail code the program writes to TOHOST and counts run cycles. It enforces a cycle-limit watchdog and buffers console characters in a small FIFO for the simulation console. Its `done` output replaces the fixed-delay stop in the top-level bench.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window
- TIMEOUT_CYCLES, 1024, RUN cycles before the watchdog fires; legal range 1..2^32-1
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high (`RstEnable` = 1)
- req_valid  in  1  bus request present
- req_ready  out  1  request accepted this cycle when req_valid and req_ready are both high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse, one per accepted request
- rsp_rdata  out  32  read data; 0 for writes and unmapped addresses
- char_valid  out  1  console FIFO not empty
- char_data  out  8  FIFO head byte
- char_ready  in  1  console consumer pops when char_valid and char_ready are both high
- done  out  1  level; high in PASS, FAIL or TIMEOUT
- pass  out  1  level; high only in PASS
- timeout  out  1  level; high only in TIMEOUT
- fail_code  out  31  TOHOST[31:1] captured on FAIL, otherwise 0

## Operation
- Register map (offset from BASE_ADDR):
  - 0x0 TOHOST: write-only; reads return 0.
  - 0x4 CYCLE_LO: read-only.
  - 0x8 CYCLE_HI: read-only.
  - 0xC CHAR: write-only; wdata[7:0] is pushed to the FIFO, wdata[31:8] is ignored.
- Address match is on req_addr[31:4] == BASE_ADDR[31:4]; offset is req_addr[3:2]; req_addr[1:0] is ignored. Non-matching requests are accepted: writes are dropped, reads return 0.
- FSM states: RUN, PASS, FAIL, TIMEOUT.
  - Reset enters RUN.
  - RUN -> PASS on an accepted TOHOST write with wdata == 1.
  - RUN -> FAIL on an accepted TOHOST write with wdata even, or odd and > 1; fail_code <= wdata[31:1].
  - A TOHOST write of 0 is ignored.
  - RUN -> TIMEOUT when cycle == TIMEOUT_CYCLES-1 and no terminating TOHOST write is accepted in that cycle; the TOHOST write wins a tie.
  - PASS, FAIL and TIMEOUT are terminal until rst. Later TOHOST writes are accepted and dropped.
- Cycle counter: 64-bit, increments every clock in RUN, frozen in terminal states, no wrap handling needed. CYCLE_LO and CYCLE_HI return the current value, not a snapshot.
- Console FIFO: circular buffer with a read pointer, a write pointer and a count.
  - CHAR writes are accepted in every state.
  - req_ready = 0 only when req_valid, req_we, address == CHAR and the FIFO is full. A pop in the same cycle does not make room, so ready never depends on char_ready.
  - All other requests always have req_ready = 1.
  - A push and a pop in the same cycle leave count unchanged.

## Timing
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, char_valid 0, char_data 0, done 0, pass 0, timeout 0, fail_code 0, cycle 0, FIFO empty, state RUN.
- A request accepted at edge N produces rsp_valid high during cycle N+1 for exactly one cycle. Back-to-back requests give back-to-back responses.
- A terminating TOHOST write accepted at edge N makes done/pass/fail_code visible after edge N; the cycle counter does not increment at that edge.
- The watchdog makes timeout visible after the edge where the counter would reach TIMEOUT_CYCLES. The counter then reads TIMEOUT_CYCLES-1.
- A byte pushed at edge N appears on char_valid/char_data after edge N, a latency of one cycle.
- rst asserted mid-operation immediately clears all state, including FIFO contents and any pending rsp_valid.

## Structure
- A shared package/defines file holds:
  - the offset constants TOHOST_OFF, CYCLE_LO_OFF, CYCLE_HI_OFF, CHAR_OFF;
  - the state encodings ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT;
  - the pass value TOHOST_PASS = 32'd1.
- Sub-module: test_char_fifo, a synchronous FIFO parameterised by width and depth with full/empty/count outputs, reusable for a later UART transmitter.

## Test plan
- Reset, then idle for 10 cycles, then read 0x4 -> rdata equals the cycle value, done 0, rsp_valid pulses one cycle after acceptance.
- Write TOHOST=1 at cycle 20 -> pass=1, done=1 next cycle; CYCLE_LO stays 20 afterwards; a later TOHOST=7 leaves pass=1 and fail_code=0.
- Write TOHOST=7 -> FAIL, fail_code=3, pass=0, done=1.
- TIMEOUT_CYCLES=16, no writes -> timeout=1 after 16 edges with CYCLE_LO=15; repeat with TOHOST=1 accepted on the 16th edge -> PASS, timeout=0.
- FIFO_DEPTH=4, char_ready=0, write 'H','E','L','L','O' -> the fifth write stalls with req_ready=0; raising char_ready drains 'H','E','L','L' in order, then 'O' is accepted.
- Assert rst while 3 bytes are queued and the FSM is in PASS -> all outputs return to reset values in the same cycle, char_valid=0, state RUN.

Source files
------------

// File: rtl/test_ctrl_mmio_pkg.sv
// Shared constants for the test-control responder: register offsets,
// FSM state encodings and the TOHOST pass value.
package test_ctrl_mmio_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [1:0] TOHOST_OFF   = 2'd0;
  localparam logic [1:0] CYCLE_LO_OFF = 2'd1;
  localparam logic [1:0] CYCLE_HI_OFF = 2'd2;
  localparam logic [1:0] CHAR_OFF     = 2'd3;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  // A TOHOST value of zero is not a result and never ends the run.
  function automatic logic is_terminating(input logic [31:0] value);
    return (value != 32'd0);
  endfunction

endpackage

// File: rtl/test_char_fifo.sv
// Synchronous circular-buffer FIFO with full/empty/count status.
// Head data reads as zero while empty so the output has a defined value.
module test_char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == DEPTH[AW:0]);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign pop_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + {{AW{1'b0}}, 1'b1};
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - {{AW{1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/test_ctrl_mmio.sv
// Memory-mapped test-control responder: TOHOST result capture, run-cycle
// counter with watchdog, and a console character FIFO.
module test_ctrl_mmio
  import test_ctrl_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code
);

  state_e      state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rdata_d;

  logic        hit_s, char_wr_s, accept_s, tohost_wr_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [1:0]  off_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused_s;
  logic        addr_unused_s;

  assign addr_unused_s = ^req_addr[1:0];
  assign hit_s         = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign off_s         = req_addr[3:2];
  assign char_wr_s     = req_valid && req_we && hit_s && (off_s == CHAR_OFF);
  // Stall only a CHAR write into a full FIFO; a same-cycle pop does not count.
  assign req_ready     = !(char_wr_s && fifo_full_s);
  assign accept_s      = req_valid && req_ready;
  assign tohost_wr_s   = accept_s && req_we && hit_s && (off_s == TOHOST_OFF);

  test_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (char_wr_s && !fifo_full_s),
    .push_data_i (req_wdata[7:0]),
    .pop_i       (char_ready),
    .pop_data_o  (char_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_unused_s)
  );

  assign char_valid = !fifo_empty_s;

  // A terminating write wins over the watchdog and freezes the counter.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_RUN: begin
        if (tohost_wr_s && (req_wdata == TOHOST_PASS)) begin
          state_d = ST_PASS;
        end else if (tohost_wr_s && is_terminating(req_wdata)) begin
          state_d     = ST_FAIL;
          fail_code_d = req_wdata[31:1];
        end else if (cycle_q == {32'd0, TIMEOUT_CYCLES - 32'd1}) begin
          state_d = ST_TIMEOUT;
        end else begin
          cycle_d = cycle_q + 64'd1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    if (accept_s && !req_we && hit_s) begin
      case (off_s)
        CYCLE_LO_OFF: rdata_d = cycle_q[31:0];
        CYCLE_HI_OFF: rdata_d = cycle_q[63:32];
        default:      rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_q     <= 64'd0;
      fail_code_q <= 31'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      fail_code_q <= fail_code_d;
      rsp_valid_q <= accept_s;
      rsp_rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign done      = (state_q != ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign timeout   = (state_q == ST_TIMEOUT);
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_test_ctrl_mmio.sv
// Directed bench: instance A uses default parameters, instance B uses a
// 16-cycle watchdog and a 4-entry FIFO; both share the same stimulus.
module tb_test_ctrl_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        char_ready = 1'b0;

  logic        req_ready_a, rsp_valid_a, char_valid_a, done_a, pass_a, timeout_a;
  logic [31:0] rsp_rdata_a;
  logic [7:0]  char_data_a;
  logic [30:0] fail_code_a;
  logic        req_ready_b, rsp_valid_b, char_valid_b, done_b, pass_b, timeout_b;
  logic [31:0] rsp_rdata_b;
  logic [7:0]  char_data_b;
  logic [30:0] fail_code_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  test_ctrl_mmio dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .char_valid(char_valid_a), .char_data(char_data_a), .char_ready(char_ready),
    .done(done_a), .pass(pass_a), .timeout(timeout_a), .fail_code(fail_code_a)
  );

  test_ctrl_mmio #(.TIMEOUT_CYCLES(32'd16), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .char_valid(char_valid_b), .char_data(char_data_b), .char_ready(char_ready),
    .done(done_b), .pass(pass_b), .timeout(timeout_b), .fail_code(fail_code_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
  endtask

  // Release reset at a falling edge so that k ticks later the counter reads k.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] exp_chars [5];
  int  idx;
  bit  o_sent;

  initial begin
    exp_chars = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    tick();
    chk("rst_req_ready", {63'd0, req_ready_a}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid_a}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata_a}, 64'd0);
    chk("rst_char_valid", {63'd0, char_valid_a}, 64'd0);
    chk("rst_char_data", {56'd0, char_data_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);

    // Cycle read after 10 idle cycles, then PASS at cycle 20.
    do_reset();
    repeat (10) tick();
    drive(1'b0, 32'h0000_1004, 32'd0);
    chk("rd_ready", {63'd0, req_ready_a}, 64'd1);
    chk("rd_rsp_before", {63'd0, rsp_valid_a}, 64'd0);
    tick();
    idle();
    chk("rd_rsp_valid", {63'd0, rsp_valid_a}, 64'd1);
    chk("rd_cycle10", {32'd0, rsp_rdata_a}, 64'd10);
    chk("rd_done0", {63'd0, done_a}, 64'd0);
    tick();
    chk("rd_rsp_pulse", {63'd0, rsp_valid_a}, 64'd0);
    repeat (8) tick();
    drive(1'b1, 32'h0000_1000, 32'd1);
    tick();
    idle();
    chk("pass_pass", {63'd0, pass_a}, 64'd1);
    chk("pass_done", {63'd0, done_a}, 64'd1);
    chk("pass_wr_rsp", {63'd0, rsp_valid_a}, 64'd1);
    chk("pass_wr_rdata", {32'd0, rsp_rdata_a}, 64'd0);
    tick();
    drive(1'b0, 32'h0000_1005, 32'd0);
    tick();
    idle();
    chk("pass_cycle_lo", {32'd0, rsp_rdata_a}, 64'd20);
    drive(1'b0, 32'h0000_1008, 32'd0);
    tick();
    idle();
    chk("pass_cycle_hi", {32'd0, rsp_rdata_a}, 64'd0);
    drive(1'b1, 32'h0000_1000, 32'd7);
    tick();
    idle();
    chk("pass_sticky", {63'd0, pass_a}, 64'd1);
    chk("pass_fail_code", {33'd0, fail_code_a}, 64'd0);
    drive(1'b0, 32'h0000_2004, 32'd0);
    tick();
    idle();
    chk("unmapped_rsp", {63'd0, rsp_valid_a}, 64'd1);
    chk("unmapped_rdata", {32'd0, rsp_rdata_a}, 64'd0);

    // TOHOST=0 ignored, TOHOST=7 fails with code 3.
    do_reset();
    drive(1'b1, 32'h0000_1000, 32'd0);
    tick();
    idle();
    chk("zero_ignored", {63'd0, done_a}, 64'd0);
    drive(1'b1, 32'h0000_1000, 32'd7);
    tick();
    idle();
    chk("fail_done", {63'd0, done_a}, 64'd1);
    chk("fail_pass", {63'd0, pass_a}, 64'd0);
    chk("fail_code", {33'd0, fail_code_a}, 64'd3);
    chk("fail_timeout", {63'd0, timeout_a}, 64'd0);

    // Async reset while in PASS with bytes queued and a response pending.
    do_reset();
    char_ready = 1'b0;
    drive(1'b1, 32'h0000_1000, 32'd1);
    tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0061);
    tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0062);
    tick();
    drive(1'b1, 32'h0000_100C, 32'h0000_0063);
    tick();
    idle();
    chk("pre_rst_pass", {63'd0, pass_a}, 64'd1);
    chk("pre_rst_char", {56'd0, char_data_a}, 64'h61);
    chk("pre_rst_rsp", {63'd0, rsp_valid_a}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rsp", {63'd0, rsp_valid_a}, 64'd0);
    chk("mid_rst_char_valid", {63'd0, char_valid_a}, 64'd0);
    chk("mid_rst_char_data", {56'd0, char_data_a}, 64'd0);
    chk("mid_rst_done", {63'd0, done_a}, 64'd0);
    chk("mid_rst_pass", {63'd0, pass_a}, 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready_a}, 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_char_valid", {63'd0, char_valid_a}, 64'd0);

    // Watchdog on instance B: 16 edges, counter frozen at 15.
    do_reset();
    repeat (15) tick();
    chk("wd_before", {63'd0, timeout_b}, 64'd0);
    tick();
    chk("wd_timeout", {63'd0, timeout_b}, 64'd1);
    chk("wd_done", {63'd0, done_b}, 64'd1);
    drive(1'b0, 32'h0000_1004, 32'd0);
    tick();
    idle();
    chk("wd_cycle_lo", {32'd0, rsp_rdata_b}, 64'd15);
    do_reset();
    repeat (15) tick();
    drive(1'b1, 32'h0000_1000, 32'd1);
    tick();
    idle();
    chk("wd_tie_pass", {63'd0, pass_b}, 64'd1);
    chk("wd_tie_timeout", {63'd0, timeout_b}, 64'd0);

    // FIFO depth 4 on instance B: fifth byte stalls until room appears.
    do_reset();
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_100C, {24'hFFFFFF, exp_chars[i]});
      chk("fifo_ready_fill", {63'd0, req_ready_b}, 64'd1);
      tick();
    end
    drive(1'b1, 32'h0000_100C, {24'hFFFFFF, exp_chars[4]});
    chk("fifo_stall", {63'd0, req_ready_b}, 64'd0);
    tick();
    char_ready = 1'b1;
    chk("fifo_stall_pop", {63'd0, req_ready_b}, 64'd0);
    idx = 0;
    o_sent = 1'b0;
    for (int t = 0; t < 20 && idx < 5; t++) begin
      if (req_valid && req_ready_b) begin
        chk("fifo_o_after_drain", {63'd0, (idx >= 1)}, 64'd1);
        o_sent = 1'b1;
      end
      if (char_valid_b) begin
        chk("fifo_order", {56'd0, char_data_b}, {56'd0, exp_chars[idx]});
        idx++;
      end
      tick();
      if (o_sent) idle();
    end
    chk("fifo_drained_count", idx, 64'd5);
    chk("fifo_o_accepted", {63'd0, o_sent}, 64'd1);
    chk("fifo_empty_end", {63'd0, char_valid_b}, 64'd0);
    char_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
